scan_chain_ctrl: RTL and testbench

//  Sequencer for the user core's scan chain (scan_in / scan_en / scan_out) and functional enable.
//  A host issues byte commands to: shift data through the chain; single-step the core N cycles;

---
 rtl/scan_chain_ctrl_if.sv | 23 ++
 rtl/scan_chain_ctrl.sv | 152 +++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_ctrl_if.sv
// Host-side command/response channel of the scan chain controller.
// The host is the master and the controller is the slave.
interface scan_chain_ctrl_if #(
   parameter int DW = 8
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [DW-1:0] cmd_arg;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_arg, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: shifts data through the core's scan chain,
// single-steps, free-runs or halts the core on host byte commands.
module scan_chain_ctrl #(
   parameter int DW        = 8,
   parameter bit RESET_RUN = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   scan_chain_ctrl_if.slave bus,
   output logic            scan_en,
   output logic            scan_in,
   input  logic            scan_out,
   output logic            core_ena,
   output logic            busy
);

   localparam int CW = DW + 1;

   localparam logic [1:0] OP_SHIFT = 2'b00;
   localparam logic [1:0] OP_STEP  = 2'b01;
   localparam logic [1:0] OP_FREE  = 2'b10;
   localparam logic [1:0] OP_HALT  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FREE,
      S_SHIFT,
      S_STEP,
      S_RESP
   } state_t;

   localparam state_t S_RST = RESET_RUN ? S_FREE : S_IDLE;

   state_t        state_q;
   state_t        state_d;
   logic [1:0]    op_q;
   logic [1:0]    op_d;
   logic [CW-1:0] cnt_q;
   logic [DW-1:0] tx_q;
   logic [DW-1:0] rx_q;
   logic          accept;
   logic          last;

   logic ready_d;
   logic rsp_valid_d;
   logic scan_en_d;
   logic core_ena_d;
   logic busy_d;

   assign accept = bus.cmd_valid & bus.cmd_ready;
   assign last   = (cnt_q == CW'(1));
   assign op_d   = accept ? bus.cmd_op : op_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RST;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_FREE: begin
            if (accept) begin
               unique case (bus.cmd_op)
                  OP_SHIFT: state_d = S_SHIFT;
                  OP_STEP:  state_d = S_STEP;
                  OP_FREE:  state_d = S_RESP;
                  OP_HALT:  state_d = S_RESP;
                  default:  state_d = S_RESP;
               endcase
            end
         end
         S_SHIFT, S_STEP: begin
            if (last) state_d = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d = (op_q == OP_FREE) ? S_FREE : S_IDLE;
            end
         end
         default: state_d = S_RST;
      endcase
   end

   // Outputs are registered, so decode them from the state being entered.
   always_comb begin
      ready_d     = (state_d == S_IDLE) || (state_d == S_FREE);
      rsp_valid_d = (state_d == S_RESP);
      scan_en_d   = (state_d == S_SHIFT);
      core_ena_d  = (state_d == S_FREE) || (state_d == S_STEP) ||
                    ((state_d == S_RESP) && (op_d == OP_FREE));
      busy_d      = (state_d == S_SHIFT) || (state_d == S_STEP) ||
                    (state_d == S_RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.cmd_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         scan_en       <= 1'b0;
         core_ena      <= RESET_RUN;
         busy          <= 1'b0;
      end else begin
         bus.cmd_ready <= ready_d;
         bus.rsp_valid <= rsp_valid_d;
         scan_en       <= scan_en_d;
         core_ena      <= core_ena_d;
         busy          <= busy_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q         <= OP_SHIFT;
         cnt_q        <= '0;
         tx_q         <= '0;
         rx_q         <= '0;
         scan_in      <= 1'b0;
         bus.rsp_data <= '0;
      end else if (accept) begin
         op_q <= bus.cmd_op;
         unique case (bus.cmd_op)
            OP_SHIFT: begin
               cnt_q   <= CW'(DW);
               scan_in <= bus.cmd_arg[0];
               tx_q    <= bus.cmd_arg >> 1;
            end
            OP_STEP: begin
               cnt_q <= (bus.cmd_arg == '0) ? {1'b1, {DW{1'b0}}}
                                            : {1'b0, bus.cmd_arg};
            end
            default: begin
               bus.rsp_data <= {{(DW-2){1'b0}}, bus.cmd_op};
            end
         endcase
      end else if (state_q == S_SHIFT) begin
         // Tail bit is sampled before the chain shifts; LSB arrives first.
         rx_q    <= {scan_out, rx_q[DW-1:1]};
         cnt_q   <= cnt_q - CW'(1);
         tx_q    <= tx_q >> 1;
         scan_in <= last ? 1'b0 : tx_q[0];
         if (last) bus.rsp_data <= {scan_out, rx_q[DW-1:1]};
      end else if (state_q == S_STEP) begin
         cnt_q <= cnt_q - CW'(1);
         if (last) bus.rsp_data <= {{(DW-2){1'b0}}, op_q};
      end
   end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: 16-bit scan register plus counter as the core model,
// response scoreboard fed at command issue and drained on rsp_valid.
module tb_scan_chain_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scan_en, scan_in, scan_out, core_ena, busy;

   scan_chain_ctrl_if #(.DW(8)) bus ();

   scan_chain_ctrl #(.DW(8), .RESET_RUN(1'b0)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .scan_en  (scan_en),
      .scan_in  (scan_in),
      .scan_out (scan_out),
      .core_ena (core_ena),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   logic [15:0] chain = 16'h1234;
   logic [15:0] ctr   = 16'h0000;
   int sen_cnt = 0;
   int ena_cnt = 0;
   int viol    = 0;
   int total   = 0;
   int bad     = 0;
   logic [7:0] q[$];

   assign scan_out = chain[0];

   always @(posedge clk) begin
      if (scan_en) chain <= {scan_in, chain[15:1]};
      if (core_ena) ctr <= ctr + 16'd1;
   end

   always @(negedge clk) begin
      if (scan_en) sen_cnt = sen_cnt + 1;
      if (core_ena) ena_cnt = ena_cnt + 1;
      if (scan_en && core_ena) viol = viol + 1;
      if (!scan_en && scan_in) viol = viol + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [7:0] arg,
                         input bit push, input logic [7:0] exp);
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.cmd_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("cmd_ready_timeout", 0, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_arg   = arg;
      if (push) q.push_back(exp);
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(input string tag);
      bit ok = 0;
      logic [7:0] exp;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         check({tag, "_timeout"}, 0, 1);
      end else begin
         exp = (q.size() > 0) ? q.pop_front() : 8'hxx;
         check(tag, 32'(bus.rsp_data), 32'(exp));
         bus.rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.rsp_ready = 1'b0;
      end
   endtask

   initial begin
      bit stable;
      logic [15:0] c0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_arg   = 8'h00;
      bus.rsp_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.cmd_ready), 1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_data", 32'(bus.rsp_data), 0);
      check("rst_scan_en", 32'(scan_en), 0);
      check("rst_scan_in", 32'(scan_in), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_core_ena", 32'(core_ena), 0);
      rst = 1'b0;

      sen_cnt = 0;
      do_cmd(2'b00, 8'hA5, 1, 8'h34);
      check("shift_busy", 32'(busy), 1);
      check("shift_ready", 32'(bus.cmd_ready), 0);
      get_rsp("shift_a5");
      check("shift_a5_len", 32'(sen_cnt), 8);
      check("chain_a512", 32'(chain), 32'h0000_A512);
      do_cmd(2'b00, 8'h00, 1, 8'h12);
      get_rsp("shift_00_a");
      do_cmd(2'b00, 8'h00, 1, 8'hA5);
      get_rsp("shift_00_b");
      do_cmd(2'b00, 8'h00, 1, 8'h00);
      get_rsp("shift_00_c");

      c0 = ctr;
      ena_cnt = 0;
      do_cmd(2'b01, 8'd3, 1, 8'h01);
      get_rsp("step3");
      check("step3_ena", 32'(ena_cnt), 3);
      check("step3_ctr", 32'(ctr - c0), 3);

      ena_cnt = 0;
      do_cmd(2'b01, 8'd0, 1, 8'h01);
      get_rsp("step0");
      check("step0_ena", 32'(ena_cnt), 256);

      do_cmd(2'b10, 8'h00, 1, 8'h02);
      get_rsp("free_ack");
      repeat (3) @(negedge clk);
      check("free_running", 32'(core_ena), 1);
      do_cmd(2'b00, 8'h0F, 1, 8'h00);
      check("free_shift_ena", 32'(core_ena), 0);
      check("free_shift_sen", 32'(scan_en), 1);
      get_rsp("free_shift");
      @(negedge clk);
      check("after_shift_idle", 32'(core_ena), 0);

      do_cmd(2'b11, 8'h00, 1, 8'h03);
      check("halt_ena", 32'(core_ena), 0);
      get_rsp("halt_ack");

      do_cmd(2'b00, 8'h3C, 1, 8'h00);
      get_rsp("shift_3c");
      do_cmd(2'b00, 8'h00, 1, 8'h0F);
      stable = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            stable = 1;
            break;
         end
      end
      check("stall_rsp_seen", 32'(stable), 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b11;
      repeat (10) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_data !== 8'h0F || bus.cmd_ready)
            stable = 0;
      end
      check("stall_stable", 32'(stable), 1);
      check("stall_busy", 32'(busy), 1);
      bus.cmd_valid = 1'b0;
      get_rsp("stall_rsp");
      check("chain_003c", 32'(chain), 32'h0000_003C);

      do_cmd(2'b00, 8'hFF, 0, 8'h00);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_scan_en", 32'(scan_en), 0);
      check("abort_rsp_valid", 32'(bus.rsp_valid), 0);
      check("abort_ready", 32'(bus.cmd_ready), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_scan_in", 32'(scan_in), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      stable = 1;
      repeat (4) begin
         @(negedge clk);
         if (bus.rsp_valid) stable = 0;
      end
      check("abort_no_rsp", 32'(stable), 1);
      check("chain_f003", 32'(chain), 32'h0000_F003);

      sen_cnt = 0;
      do_cmd(2'b00, 8'h5A, 1, 8'h03);
      get_rsp("post_abort_shift");
      check("post_abort_len", 32'(sen_cnt), 8);
      check("chain_5af0", 32'(chain), 32'h0000_5AF0);

      check("no_overlap", 32'(viol), 0);
      check("queue_empty", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
